// File: rtl/kian_mem_pkg.sv
// Shared types and address decode for the kianv native-interface memory responder.
package kian_mem_pkg;

  localparam logic [31:0] DONE_ADDR_DEF = 32'h3000_0000;
  localparam logic [31:0] CNT_ADDR_DEF  = 32'h3000_0008;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef enum logic [2:0] {REG_RAM, REG_DONE, REG_CNTLO, REG_CNTHI, REG_NONE} region_t;

  typedef struct packed {
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  // Word-granular decode; byte-offset bits of every address are ignored.
  function automatic region_t decode(input logic [31:0] addr, input logic [31:0] words,
                                     input logic [31:0] done_addr, input logic [31:0] cnt_addr);
    logic [29:0] idx;
    idx = addr[31:2];
    if ({2'b00, idx} < words) return REG_RAM;
    if (idx == done_addr[31:2]) return REG_DONE;
    if (idx == cnt_addr[31:2]) return REG_CNTLO;
    if (idx == cnt_addr[31:2] + 30'd1) return REG_CNTHI;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/kian_mem_array.sv
// Single-port synchronous RAM with byte write mask and registered read data.
module kian_mem_array #(
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned AW        = 12
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [MEM_WORDS];

  // Read data only moves on a read, so it stays stable across a following write.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
      if (we == 4'b0000) rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/kian_mem_responder.sv
// Handshaking responder for the kianv memory bus: wait states, byte-masked RAM,
// sticky sim_done, 64-bit counter with shadowed high word, and access_fault.
module kian_mem_responder
  import kian_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned LATENCY   = 2,
  parameter logic [31:0] DONE_ADDR = DONE_ADDR_DEF,
  parameter logic [31:0] CNT_ADDR  = CNT_ADDR_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        access_fault,
  output logic [63:0] counter,
  output logic        sim_done
);

  localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned CW = 4;

  state_t        state, state_next;
  logic [CW-1:0] wait_cnt, wait_cnt_next;
  req_t          req_q;
  logic [AW-1:0] idx_q;
  region_t       region_q;
  logic [63:0]   cnt_q;
  logic [31:0]   shadow_q;
  logic [31:0]   hold_q;
  logic          done_q;
  logic          ready_q;
  logic          fault_q;

  region_t       region_in;
  region_t       rd_region_c;
  logic [AW-1:0] rd_idx_c;
  logic          rd_en_c;
  logic          wr_en_c;
  logic          arr_en_c;
  logic [3:0]    arr_we_c;
  logic [AW-1:0] arr_addr_c;
  logic [31:0]   arr_rdata;
  logic [31:0]   resp_data_c;

  assign region_in = decode(mem_addr, 32'(MEM_WORDS), DONE_ADDR, CNT_ADDR);

  // Next-state logic for the request handshake.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    unique case (state)
      IDLE: begin
        if (mem_valid) begin
          wait_cnt_next = CW'(LATENCY);
          state_next    = (LATENCY > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        wait_cnt_next = wait_cnt - CW'(1);
        if (wait_cnt <= CW'(1)) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // RAM read goes out the cycle before RESP; with no wait states that is the sampling cycle itself.
  assign rd_region_c = (state == IDLE) ? region_in : region_q;
  assign rd_idx_c    = (state == IDLE) ? mem_addr[AW+1:2] : idx_q;
  assign rd_en_c     = resetn && (state_next == RESP) && (rd_region_c == REG_RAM);
  assign wr_en_c     = resetn && (state == RESP) && (region_q == REG_RAM) && (req_q.wstrb != 4'b0000);
  assign arr_en_c    = rd_en_c || wr_en_c;
  assign arr_we_c    = wr_en_c ? req_q.wstrb : 4'b0000;
  assign arr_addr_c  = (state == RESP) ? idx_q : rd_idx_c;

  kian_mem_array #(
    .MEM_WORDS(MEM_WORDS),
    .AW       (AW)
  ) u_array (
    .clk  (clk),
    .en   (arr_en_c),
    .we   (arr_we_c),
    .addr (arr_addr_c),
    .wdata(req_q.wdata),
    .rdata(arr_rdata)
  );

  always_comb begin
    resp_data_c = 32'h0;
    unique case (region_q)
      REG_RAM:   resp_data_c = arr_rdata;
      REG_DONE:  resp_data_c = {31'b0, done_q};
      REG_CNTLO: resp_data_c = cnt_q[31:0];
      REG_CNTHI: resp_data_c = shadow_q;
      default:   resp_data_c = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      wait_cnt <= '0;
      req_q    <= '0;
      idx_q    <= '0;
      region_q <= REG_NONE;
      ready_q  <= 1'b0;
      fault_q  <= 1'b0;
      hold_q   <= '0;
      shadow_q <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      ready_q  <= (state_next == RESP);
      fault_q  <= (state_next == RESP) && (rd_region_c == REG_NONE);
      if (state == IDLE && mem_valid) begin
        req_q    <= '{wdata: mem_wdata, wstrb: mem_wstrb};
        idx_q    <= mem_addr[AW+1:2];
        region_q <= region_in;
      end
      if (state == RESP) begin
        hold_q <= resp_data_c;
        if (region_q == REG_CNTLO && req_q.wstrb == 4'b0000) shadow_q <= cnt_q[63:32];
      end
    end
  end

  // Counter and done flag run independently of the handshake.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 64'd1;
      if (state == RESP && region_q == REG_DONE && req_q.wstrb != 4'b0000) done_q <= 1'b1;
    end
  end

  assign mem_ready    = ready_q;
  assign access_fault = fault_q;
  assign mem_rdata    = (state == RESP) ? resp_data_c : hold_q;
  assign counter      = cnt_q;
  assign sim_done     = done_q;

endmodule

// File: tb/tb_kian_mem_responder.sv
// Scoreboard bench for kian_mem_responder: one instance with two wait states, one with none.
`timescale 1ns/1ps
module tb_kian_mem_responder;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic        valid, ready, fault, done;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  wstrb;
  logic [63:0] counter;

  logic        valid0, ready0, fault0, done0;
  logic [31:0] addr0, wdata0, rdata0;
  logic [3:0]  wstrb0;
  logic [63:0] counter0;

  kian_mem_responder #(.LATENCY(2)) dut (
    .clk(clk), .resetn(resetn), .mem_valid(valid), .mem_ready(ready), .mem_addr(addr),
    .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_rdata(rdata), .access_fault(fault),
    .counter(counter), .sim_done(done)
  );

  kian_mem_responder #(.LATENCY(0)) dut0 (
    .clk(clk), .resetn(resetn), .mem_valid(valid0), .mem_ready(ready0), .mem_addr(addr0),
    .mem_wdata(wdata0), .mem_wstrb(wstrb0), .mem_rdata(rdata0), .access_fault(fault0),
    .counter(counter0), .sim_done(done0)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        chk_rdata;
    logic        fault;
    int          due;
  } exp_t;

  exp_t        q2[$];
  exp_t        q0[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] model = '0;
  logic [63:0] ofs = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    model <= resetn ? model + 64'd1 : 64'd0;
  end

  always @(negedge clk) begin
    if (resetn) begin
      if (ready) begin
        if (q2.size() == 0) check("lat2_spurious_ready", 64'd1, 64'd0);
        else begin
          exp_t e;
          e = q2.pop_front();
          check("lat2_cycle", 64'(cyc), 64'(e.due));
          if (e.chk_rdata) check("lat2_rdata", 64'(rdata), 64'(e.rdata));
          check("lat2_fault", 64'(fault), 64'(e.fault));
        end
      end else if (fault) check("lat2_fault_without_ready", 64'd1, 64'd0);
    end
  end

  always @(negedge clk) begin
    if (resetn) begin
      if (ready0) begin
        if (q0.size() == 0) check("lat0_spurious_ready", 64'd1, 64'd0);
        else begin
          exp_t e;
          e = q0.pop_front();
          check("lat0_cycle", 64'(cyc), 64'(e.due));
          if (e.chk_rdata) check("lat0_rdata", 64'(rdata0), 64'(e.rdata));
          check("lat0_fault", 64'(fault0), 64'(e.fault));
        end
      end else if (fault0) check("lat0_fault_without_ready", 64'd1, 64'd0);
    end
  end

  task automatic xact2(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic [31:0] er, input logic chk, input logic ef);
    exp_t e;
    int   n;
    @(negedge clk);
    valid = 1'b1; addr = a; wdata = d; wstrb = s;
    e.rdata = er; e.chk_rdata = chk; e.fault = ef; e.due = cyc + 3;
    q2.push_back(e);
    n = 0;
    do begin @(negedge clk); n++; end while (!ready && n < 20);
    if (!ready) begin
      check("lat2_timeout", 64'd0, 64'd1);
      q2.delete(q2.size() - 1);
    end
    valid = 1'b0;
  endtask

  task automatic xact0(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic [31:0] er, input logic chk, input logic ef);
    exp_t e;
    int   n;
    @(negedge clk);
    valid0 = 1'b1; addr0 = a; wdata0 = d; wstrb0 = s;
    e.rdata = er; e.chk_rdata = chk; e.fault = ef; e.due = cyc + 1;
    q0.push_back(e);
    n = 0;
    do begin @(negedge clk); n++; end while (!ready0 && n < 20);
    if (!ready0) begin
      check("lat0_timeout", 64'd0, 64'd1);
      q0.delete(q0.size() - 1);
    end
    valid0 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] v;
    exp_t        e;
    valid = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    valid0 = 1'b0; addr0 = '0; wdata0 = '0; wstrb0 = '0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_fault", 64'(fault), 64'd0);
    check("rst_counter", counter, 64'd0);
    check("rst_sim_done", 64'(done), 64'd0);
    resetn = 1'b1;
    @(negedge clk);
    check("counter_run", counter, model + ofs);

    // Full-word write then read back
    xact2(32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 1'b0);
    xact2(32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b1, 1'b0);

    // Byte-masked write returns the pre-write word
    xact2(32'h20, 32'h1122_3344, 4'hF, 32'h0, 1'b0, 1'b0);
    xact2(32'h20, 32'h0000_00AA, 4'b0001, 32'h1122_3344, 1'b1, 1'b0);
    xact2(32'h20, 32'h0, 4'h0, 32'h1122_33AA, 1'b1, 1'b0);

    // Unmapped write faults and must not alias onto RAM word 0
    xact2(32'h0, 32'h0BAD_CAFE, 4'hF, 32'h0, 1'b0, 1'b0);
    xact2(32'h4000_0000, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 1'b1);
    xact2(32'h0, 32'h0, 4'h0, 32'h0BAD_CAFE, 1'b1, 1'b0);

    // Counter split read across a carry into the high word
    v = 64'h0000_0000_FFFF_FFF8;
    @(negedge clk);
    force dut.cnt_q = v;
    @(negedge clk);
    release dut.cnt_q;
    ofs = v - model;
    xact2(32'h3000_0008, 32'h0, 4'h0, 32'(v + 64'd4), 1'b1, 1'b0);
    xact2(32'h3000_000C, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0);
    check("counter_hi_after_carry", 64'(counter[63:32]), 64'd1);
    check("counter_track", counter, model + ofs);
    xact2(32'h3000_0008, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 1'b0);

    // sim_done set, sticky, readable
    xact2(32'h3000_0000, 32'h1, 4'hF, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    check("sim_done_set", 64'(done), 64'd1);
    xact2(32'h3000_0000, 32'h0, 4'h0, 32'h1, 1'b1, 1'b0);
    check("sim_done_sticky", 64'(done), 64'd1);

    // Reset in WAIT aborts the write
    xact2(32'h80, 32'h55AA_55AA, 4'hF, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    valid = 1'b1; addr = 32'h80; wdata = 32'hFFFF_0000; wstrb = 4'hF;
    @(negedge clk);
    resetn = 1'b0; valid = 1'b0; ofs = '0;
    @(negedge clk);
    resetn = 1'b1;
    check("abort_sim_done", 64'(done), 64'd0);
    repeat (4) begin
      @(negedge clk);
      check("abort_no_ready", 64'(ready), 64'd0);
    end
    xact2(32'h80, 32'h0, 4'h0, 32'h55AA_55AA, 1'b1, 1'b0);
    check("counter_after_reset", counter, model + ofs);

    // Zero wait states: held mem_valid gives a response every second cycle
    xact0(32'h40, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    valid0 = 1'b1; addr0 = 32'h40; wdata0 = '0; wstrb0 = 4'h0;
    for (int i = 0; i < 3; i++) begin
      e.rdata = 32'hCAFE_F00D; e.chk_rdata = 1'b1; e.fault = 1'b0; e.due = cyc + 1 + 2*i;
      q0.push_back(e);
    end
    repeat (5) @(negedge clk);
    valid0 = 1'b0;
    repeat (3) @(negedge clk);
    check("lat0_queue_drained", 64'(q0.size()), 64'd0);
    check("lat2_queue_drained", 64'(q2.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
